// File: rtl/ex_mem_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : ex_mem_stage_if
// Description : Bundle of the execute-side and memory-side handshake and
//               payload signals of the EX/MEM pipeline register.
//               modport master : the surrounding pipeline (drives E side and
//                                readyM, observes readyE and the M side)
//               modport slave  : the EX/MEM stage itself
// Ports       : validE/readyE/flush, E payload in; validM/readyM, M payload out
// Revision    : 1.0 - initial release
// ============================================================================
interface ex_mem_stage_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ROM_WIDTH  = 12,
  parameter int RF_WIDTH   = 5
);
  // Execute side
  logic                  validE;
  logic                  readyE;
  logic                  flush;
  logic                  regWriteE;
  logic [1:0]            resultSelE;
  logic                  memWriteE;
  logic [DATA_WIDTH-1:0] aluResultE;
  logic [DATA_WIDTH-1:0] memDinE;
  logic [RF_WIDTH-1:0]   regAddr3E;
  logic [ROM_WIDTH-1:0]  pcE;
  logic [DATA_WIDTH-1:0] immExtE;
  logic [2:0]            memCtrlE;
  // Memory side
  logic                  validM;
  logic                  readyM;
  logic                  regWriteM;
  logic [1:0]            resultSelM;
  logic                  memWriteM;
  logic [DATA_WIDTH-1:0] aluResultM;
  logic [DATA_WIDTH-1:0] memDinM;
  logic [RF_WIDTH-1:0]   regAddr3M;
  logic [ROM_WIDTH-1:0]  pcM;
  logic [DATA_WIDTH-1:0] immExtM;
  logic [2:0]            memCtrlM;

  modport master (
    output validE, flush, regWriteE, resultSelE, memWriteE, aluResultE,
           memDinE, regAddr3E, pcE, immExtE, memCtrlE, readyM,
    input  readyE, validM, regWriteM, resultSelM, memWriteM, aluResultM,
           memDinM, regAddr3M, pcM, immExtM, memCtrlM
  );

  modport slave (
    input  validE, flush, regWriteE, resultSelE, memWriteE, aluResultE,
           memDinE, regAddr3E, pcE, immExtE, memCtrlE, readyM,
    output readyE, validM, regWriteM, resultSelM, memWriteM, aluResultM,
           memDinM, regAddr3M, pcM, immExtM, memCtrlM
  );
endinterface
`default_nettype wire

// File: rtl/ex_mem_stage.sv
`default_nettype none
// ============================================================================
// Module      : ex_mem_stage
// Description : EX/MEM pipeline register with valid/ready handshake on both
//               sides, flush and optional one-entry skid buffer.
//               Optional feature macro: SKID_BUFFER_EN
//                 defined   : skid entry, readyE decoded from state only
//                 undefined : single output register, readyE = !validM||readyM
// Ports       : clk  - clock, rising edge
//               rst  - synchronous active-high reset
//               bus  - ex_mem_stage_if.slave (E payload in, M payload out,
//                      validE/readyE, validM/readyM, flush)
// Revision    : 1.0 - initial release
// ============================================================================
module ex_mem_stage #(
  parameter int DATA_WIDTH = 32,
  parameter int ROM_WIDTH  = 12,
  parameter int RF_WIDTH   = 5
) (
  input  logic           clk,
  input  logic           rst,
  ex_mem_stage_if.slave  bus
);

  typedef struct packed {
    logic                  regWrite;
    logic [1:0]            resultSel;
    logic                  memWrite;
    logic [DATA_WIDTH-1:0] aluResult;
    logic [DATA_WIDTH-1:0] memDin;
    logic [RF_WIDTH-1:0]   regAddr3;
    logic [ROM_WIDTH-1:0]  pc;
    logic [DATA_WIDTH-1:0] immExt;
    logic [2:0]            memCtrl;
  } payload_t;

`ifdef SKID_BUFFER_EN
  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,  // nothing held
    S_ONE   = 2'd1,  // output register full
    S_TWO   = 2'd2   // output register and skid entry full
  } state_t;
`else
  typedef enum logic [0:0] {
    S_EMPTY = 1'b0,
    S_ONE   = 1'b1
  } state_t;
`endif

  state_t   state_q, state_d;
  payload_t out_q, out_d;
  payload_t w_in;
  logic     w_validM;
  logic     w_readyE;
  logic     w_accept;
  logic     w_drain;

  assign w_in = '{
    regWrite:  bus.regWriteE,
    resultSel: bus.resultSelE,
    memWrite:  bus.memWriteE,
    aluResult: bus.aluResultE,
    memDin:    bus.memDinE,
    regAddr3:  bus.regAddr3E,
    pc:        bus.pcE,
    immExt:    bus.immExtE,
    memCtrl:   bus.memCtrlE
  };

  assign w_validM = (state_q != S_EMPTY);
  assign w_accept = bus.validE && w_readyE;
  assign w_drain  = w_validM && bus.readyM;

`ifdef SKID_BUFFER_EN
  payload_t skid_q, skid_d;

  // Depends on the state register only, so readyM never reaches readyE
  // combinationally.
  assign w_readyE = (state_q != S_TWO);

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    skid_d  = skid_q;
    if (bus.flush) begin
      // Flush overrides any accept/drain and drops the incoming payload.
      state_d = S_EMPTY;
      out_d   = '0;
      skid_d  = '0;
    end else begin
      case (state_q)
        S_EMPTY: begin
          if (w_accept) begin
            out_d   = w_in;
            state_d = S_ONE;
          end
        end
        S_ONE: begin
          if (w_accept && w_drain) begin
            out_d = w_in;
          end else if (w_accept) begin
            // Output stalled: park the new payload behind it.
            skid_d  = w_in;
            state_d = S_TWO;
          end else if (w_drain) begin
            state_d = S_EMPTY;
          end
        end
        S_TWO: begin
          // readyE is low here, so only a drain can happen.
          if (w_drain) begin
            out_d   = skid_q;
            skid_d  = '0;
            state_d = S_ONE;
          end
        end
        default: begin
          state_d = S_EMPTY;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_EMPTY;
      out_q   <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      skid_q  <= skid_d;
    end
  end
`else
  // Without a skid entry a new payload can only enter when the output
  // register is empty or leaving in the same cycle.
  assign w_readyE = !w_validM || bus.readyM;

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    if (bus.flush) begin
      state_d = S_EMPTY;
      out_d   = '0;
    end else begin
      case (state_q)
        S_EMPTY: begin
          if (w_accept) begin
            out_d   = w_in;
            state_d = S_ONE;
          end
        end
        S_ONE: begin
          if (w_accept) begin
            out_d = w_in;
          end else if (w_drain) begin
            state_d = S_EMPTY;
          end
        end
        default: begin
          state_d = S_EMPTY;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_EMPTY;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
    end
  end
`endif

  assign bus.readyE     = w_readyE;
  assign bus.validM     = w_validM;
  // Side-effecting controls are masked so a bubble never writes anything.
  assign bus.regWriteM  = out_q.regWrite && w_validM;
  assign bus.memWriteM  = out_q.memWrite && w_validM;
  assign bus.resultSelM = out_q.resultSel;
  assign bus.aluResultM = out_q.aluResult;
  assign bus.memDinM    = out_q.memDin;
  assign bus.regAddr3M  = out_q.regAddr3;
  assign bus.pcM        = out_q.pc;
  assign bus.immExtM    = out_q.immExt;
  assign bus.memCtrlM   = out_q.memCtrl;

endmodule
`default_nettype wire

// File: tb/tb_ex_mem_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_ex_mem_stage
// Description : Directed self-checking bench for ex_mem_stage: reset,
//               streaming, backpressure, flush while full, and reset+flush
//               in the same cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ex_mem_stage;

  localparam int DATA_WIDTH = 32;
  localparam int ROM_WIDTH  = 12;
  localparam int RF_WIDTH   = 5;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  ex_mem_stage_if #(
    .DATA_WIDTH(DATA_WIDTH),
    .ROM_WIDTH (ROM_WIDTH),
    .RF_WIDTH  (RF_WIDTH)
  ) bus ();

  ex_mem_stage #(
    .DATA_WIDTH(DATA_WIDTH),
    .ROM_WIDTH (ROM_WIDTH),
    .RF_WIDTH  (RF_WIDTH)
  ) u_dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Fill every E field with a value derived from i so field mix-ups show.
  task automatic set_payload(input int i);
    bus.regWriteE  = 1'b1;
    bus.resultSelE = 2'(i);
    bus.memWriteE  = 1'b1;
    bus.aluResultE = 32'h10 + 32'(i);
    bus.memDinE    = 32'hA000 + 32'(i);
    bus.regAddr3E  = 5'(i + 1);
    bus.pcE        = 12'(4 * i);
    bus.immExtE    = 32'(i * 3);
    bus.memCtrlE   = 3'(i);
  endtask

  logic [ROM_WIDTH-1:0] pcs [3];
  int                   idx;
  int                   exp_idx;
  logic                 rdy;

  // Sample readyE before the edge, advance the pc list on acceptance.
  task automatic bp_step();
    rdy = bus.readyE;
    tick();
    if (rdy && bus.validE) idx++;
    if (idx < 3) begin
      bus.pcE    = pcs[idx];
      bus.validE = 1'b1;
    end else begin
      bus.validE = 1'b0;
    end
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    pcs[0] = 12'h004;
    pcs[1] = 12'h008;
    pcs[2] = 12'h00C;

    // ---------------- reset with validE high ----------------
    rst       = 1'b1;
    bus.flush = 1'b0;
    bus.readyM = 1'b1;
    bus.validE = 1'b1;
    set_payload(5);
    tick();
    tick();
    check("rst_validM",   64'(bus.validM),     64'h0);
    check("rst_regWrite", 64'(bus.regWriteM),  64'h0);
    check("rst_memWrite", 64'(bus.memWriteM),  64'h0);
    check("rst_alu",      64'(bus.aluResultM), 64'h0);
    rst        = 1'b0;
    bus.validE = 1'b0;
    #1;
    check("rst_readyE", 64'(bus.readyE), 64'h1);

    // ---------------- streaming 8 payloads ----------------
    bus.readyM = 1'b1;
    for (int i = 0; i < 8; i++) begin
      set_payload(i);
      bus.validE = 1'b1;
      #1;
      check("stream_readyE", 64'(bus.readyE), 64'h1);
      tick();
      check("stream_validM", 64'(bus.validM),     64'h1);
      check("stream_alu",    64'(bus.aluResultM), 64'h10 + 64'(i));
      check("stream_rd",     64'(bus.regAddr3M),  64'(i + 1));
      check("stream_imm",    64'(bus.immExtM),    64'(i * 3));
      check("stream_din",    64'(bus.memDinM),    64'hA000 + 64'(i));
      check("stream_rsel",   64'(bus.resultSelM), 64'(i % 4));
      check("stream_mctl",   64'(bus.memCtrlM),   64'(i % 8));
      check("stream_regW",   64'(bus.regWriteM),  64'h1);
    end
    bus.validE = 1'b0;
    tick();
    check("stream_end_validM", 64'(bus.validM),    64'h0);
    check("stream_end_regW",   64'(bus.regWriteM), 64'h0);
    check("stream_end_memW",   64'(bus.memWriteM), 64'h0);

    // ---------------- backpressure ----------------
    set_payload(1);
    idx        = 0;
    bus.pcE    = pcs[0];
    bus.validE = 1'b1;
    bus.readyM = 1'b0;
    #1;
    for (int c = 0; c < 3; c++) bp_step();
`ifdef SKID_BUFFER_EN
    exp_idx = 2;  // 0x004 on M, 0x008 in skid, 0x00C waiting
`else
    exp_idx = 1;  // 0x004 on M, 0x008 waiting
`endif
    check("bp_pcM",     64'(bus.pcM),    64'h004);
    check("bp_validM",  64'(bus.validM), 64'h1);
    check("bp_readyE",  64'(bus.readyE), 64'h0);
    check("bp_accepted", 64'(idx),       64'(exp_idx));
    bus.readyM = 1'b1;
    #1;
    for (int k = 1; k < 3; k++) begin
      bp_step();
      check("bp_order_pc",    64'(bus.pcM),    64'(pcs[k]));
      check("bp_order_valid", 64'(bus.validM), 64'h1);
    end
    check("bp_all_accepted", 64'(idx), 64'h3);
    tick();
    check("bp_drained", 64'(bus.validM), 64'h0);

    // ---------------- flush while full ----------------
    set_payload(2);
    bus.validE = 1'b1;
    bus.readyM = 1'b0;
    #1;
    for (int c = 0; c < 5; c++) begin
      if (!bus.readyE) break;
      tick();
    end
    check("fl_full_readyE", 64'(bus.readyE), 64'h0);
    check("fl_full_validM", 64'(bus.validM), 64'h1);
    bus.flush = 1'b1;
    tick();
    bus.flush  = 1'b0;
    bus.validE = 1'b0;
    #1;
    check("fl_validM", 64'(bus.validM),    64'h0);
    check("fl_regW",   64'(bus.regWriteM), 64'h0);
    check("fl_memW",   64'(bus.memWriteM), 64'h0);
    check("fl_readyE", 64'(bus.readyE),    64'h1);
    bus.readyM = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      check("fl_no_ghost", 64'(bus.validM), 64'h0);
    end

    // ---------------- reset + flush + validE together ----------------
    set_payload(3);
    bus.aluResultE = 32'h1234;
    bus.validE     = 1'b1;
    bus.flush      = 1'b1;
    rst            = 1'b1;
    tick();
    check("sim_validM", 64'(bus.validM),     64'h0);
    check("sim_alu",    64'(bus.aluResultM), 64'h0);
    check("sim_regW",   64'(bus.regWriteM),  64'h0);
    rst            = 1'b0;
    bus.flush      = 1'b0;
    bus.aluResultE = 32'hABCD;
    #1;
    check("sim_readyE", 64'(bus.readyE), 64'h1);
    tick();
    bus.validE = 1'b0;
    check("sim_alu_abcd", 64'(bus.aluResultM), 64'hABCD);
    check("sim_validM2",  64'(bus.validM),     64'h1);
    tick();
    check("sim_drained", 64'(bus.validM), 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
